output_backprop: RTL and testbench
==================================

# output_backprop

Backward-pass companion to the fully connected output layer. It takes the N_OUT output-error terms and walks the same N_IN×N_OUT weight matrix in transposed order. For each input index j it computes delta[j] = sat(Σ_i err[i]·w[j][i] >>> SHIFT) and streams the N_IN results out over a valid/ready interface. It sits between the output-layer error generator and the hidden-layer gradient logic, and reads weights through a synchronous one-row-per-address memory port.

## Interface
- DATA_W, 9: width of errors, weights and deltas (signed fixed point)
- N_IN, 128: number of input activations, which is also the number of deltas produced
- N_OUT, 3: number of output nodes and error terms
- SHIFT, 9: arithmetic right shift applied to the accumulated sum
- ACC_W, 20: accumulator width, enough for N_OUT full-scale products
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  request a backward pass
- start_ready  out  1  high only in IDLE
- err_in  in  N_OUT*DATA_W  error terms; err[i] = err_in[i*DATA_W +: DATA_W]; sampled on start handshake
- w_rd_en  out  1  weight row read strobe
- w_addr  out  $clog2(N_IN)  row index j
- w_rd_data  in  N_OUT*DATA_W  row j weights, w[j][i] in the same packing; valid the cycle after w_rd_en
- delta_valid  out  1  delta_data valid
- delta_ready  in  1  consumer accepts
- delta_data  out  DATA_W  signed delta[j]
- delta_idx  out  $clog2(N_IN)  j of the current delta
- delta_last  out  1  high with delta_idx = N_IN-1
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, FETCH, MAC, OUT.
- IDLE
  - start_ready = 1.
  - On start_valid, latch err[0..N_OUT-1], set j = 0, go to FETCH.
- FETCH
  - Assert w_rd_en for one cycle with w_addr = j.
  - Go to MAC.
- MAC
  - Multiply w_rd_data signed by the latched err, DATA_W×DATA_W → 2·DATA_W.
  - Sign-extend each product to ACC_W and sum the N_OUT products.
  - Arithmetic-shift the sum right by SHIFT, which floors toward −∞.
  - Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Register the result into delta_data, set delta_idx = j and delta_last = (j == N_IN−1).
  - Go to OUT.
- OUT
  - Hold delta_valid = 1.
  - delta_data, delta_idx and delta_last stay stable until delta_valid & delta_ready.
  - On handshake: if delta_last, go to IDLE; otherwise j = j+1 and go to FETCH.
- Errors are latched once per pass. Changes on err_in during busy have no effect.
- start_valid during busy is ignored, because start_ready = 0. No queuing.
- w_rd_en is asserted only in FETCH. w_addr holds its last value otherwise.
- rst in any state
  - Next cycle: IDLE, j = 0, all strobes and valids low.
  - A partially streamed pass is abandoned, and no delta_last is issued for it.

## Timing
- Reset values
  - start_ready = 1, busy = 0, w_rd_en = 0, w_addr = 0.
  - delta_valid = 0, delta_data = 0, delta_idx = 0, delta_last = 0.
- Start handshake at cycle T:
  - w_rd_en high at T+1 (FETCH).
  - Weight data captured at T+2 (MAC).
  - delta_valid high from T+3.
- With delta_ready held high, each delta costs 3 cycles (FETCH, MAC, OUT).
  - A full pass is 3·N_IN cycles after the start handshake: 384 at defaults.
  - start_ready returns high the cycle after the last handshake.
- Backpressure
  - Each cycle of delta_ready low adds one cycle.
  - No weight reads are issued while stalled.
- delta_ready high while delta_valid is low has no effect.

## Test plan
- Basic scaling: err = (64, 0, 0), every row w = (8, x, x) → 128 deltas of value 1, idx 0..127, delta_last only on idx 127, 384 cycles with ready tied high.
- Positive saturation: err = (255, 255, 255), w = (255, 255, 255) → sum 195075, shifted 381 → delta 255.
- Negative saturation and flooring:
  - err = (−256, −256, −256), w = (255, 255, 255) → −256.
  - err = (−1, 0, 0), w = (1, 0, 0) → −1, not 0.
- Backpressure: random delta_ready with ~50% duty → delta_data and delta_idx stable while stalled, one w_rd_en per delta (128 total), results match the golden model.
- Start while busy: pulse start_valid with a different err_in mid-pass → ignored, start_ready stays 0, all deltas use the original errors.
- Reset mid-pass: assert rst during OUT at idx 40 → next cycle delta_valid = 0, start_ready = 1; a new pass then runs cleanly from idx 0.

Source files
------------

// File: rtl/output_backprop.sv
// rtl/output_backprop.sv - transposed weight walk producing saturated, shifted output-layer deltas
module output_backprop #(
  parameter int DATA_W = 9,
  parameter int N_IN   = 128,
  parameter int N_OUT  = 3,
  parameter int SHIFT  = 9,
  parameter int ACC_W  = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [N_OUT*DATA_W-1:0]    err_in,
  output logic                       w_rd_en,
  output logic [$clog2(N_IN)-1:0]    w_addr,
  input  logic [N_OUT*DATA_W-1:0]    w_rd_data,
  output logic                       delta_valid,
  input  logic                       delta_ready,
  output logic [DATA_W-1:0]          delta_data,
  output logic [$clog2(N_IN)-1:0]    delta_idx,
  output logic                       delta_last,
  output logic                       busy
);
  localparam int AW = $clog2(N_IN);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, FETCH, MAC, OUT} state_t;

  state_t                    state, state_n;
  logic [AW-1:0]             j;
  logic [N_OUT*DATA_W-1:0]   err_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         sat;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign w_rd_en     = (state == FETCH);
  assign delta_valid = (state == OUT);
  // j only moves on entry to FETCH, so it doubles as the held read address
  assign w_addr      = j;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_valid) state_n = FETCH;
      FETCH:   state_n = MAC;
      MAC:     state_n = OUT;
      OUT:     if (delta_ready) state_n = delta_last ? IDLE : FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int i = 0; i < N_OUT; i++) begin
      prod = (2*DATA_W)'($signed(err_q[i*DATA_W +: DATA_W])) *
             (2*DATA_W)'($signed(w_rd_data[i*DATA_W +: DATA_W]));
      acc  = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
    shifted = acc >>> SHIFT;
    if (shifted > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                        sat = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      j          <= '0;
      err_q      <= '0;
      delta_data <= '0;
      delta_idx  <= '0;
      delta_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            err_q <= err_in;
            j     <= '0;
          end
        end
        MAC: begin
          delta_data <= sat;
          delta_idx  <= j;
          delta_last <= (j == AW'(N_IN - 1));
        end
        OUT: begin
          if (delta_ready && !delta_last) j <= j + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_output_backprop.sv
// tb/tb_output_backprop.sv - directed self-checking bench for output_backprop
module tb_output_backprop;
  localparam int DATA_W = 9;
  localparam int N_IN   = 128;
  localparam int N_OUT  = 3;
  localparam int SHIFT  = 9;
  localparam int ACC_W  = 20;
  localparam int AW     = 7;
  localparam int EW     = N_OUT * DATA_W;

  logic              clk = 1'b0;
  logic              rst, start_valid, start_ready, w_rd_en;
  logic              delta_valid, delta_ready, delta_last, busy;
  logic [EW-1:0]     err_in, w_rd_data;
  logic [AW-1:0]     w_addr, delta_idx;
  logic [DATA_W-1:0] delta_data;
  logic [EW-1:0]     w_mem [N_IN];
  int                n_cmp = 0;
  int                n_err = 0;

  output_backprop #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SHIFT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .err_in(err_in), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .delta_valid(delta_valid), .delta_ready(delta_ready), .delta_data(delta_data),
    .delta_idx(delta_idx), .delta_last(delta_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (w_rd_en) w_rd_data <= w_mem[w_addr];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, floor division, clamp
  function automatic logic signed [31:0] model(input logic [EW-1:0] e, input logic [EW-1:0] w);
    int s, q;
    logic signed [DATA_W-1:0] a, b;
    s = 0;
    for (int i = 0; i < N_OUT; i++) begin
      a = e[i*DATA_W +: DATA_W];
      b = w[i*DATA_W +: DATA_W];
      s += int'(a) * int'(b);
    end
    q = s / (1 << SHIFT);
    if (s < 0 && q * (1 << SHIFT) != s) q = q - 1;
    if (q > 255)  q = 255;
    if (q < -256) q = -256;
    return q;
  endfunction

  task automatic fill_const(input logic [EW-1:0] row);
    for (int k = 0; k < N_IN; k++) w_mem[k] = row;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N_IN; k++) w_mem[k] = EW'($urandom);
  endtask

  task automatic do_pass(input string name, input logic [EW-1:0] e, input bit rnd, input bit use_hand,
                         input logic signed [31:0] hand, input int abort_at, input bit inject);
    int k = 0;
    int busy_cyc = 0;
    int rd_cnt = 0;
    bit done = 0;
    bit prev_stall = 0;
    bit hs, rdy;
    logic [DATA_W-1:0] held_d;
    logic [AW-1:0] held_i;
    logic signed [31:0] exp;
    err_in = e;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    err_in = ~e;
    check({name, "_fetch_rd_en"}, 32'(w_rd_en), 1);
    check({name, "_fetch_addr"}, 32'(w_addr), 0);
    for (int c = 0; c < 2000 && !done; c++) begin
      start_valid = 1'b0;
      if (busy) busy_cyc++;
      if (w_rd_en) rd_cnt++;
      if (delta_valid) begin
        if (prev_stall) begin
          check({name, "_stall_data"}, 32'($signed(delta_data)), 32'($signed(held_d)));
          check({name, "_stall_idx"}, 32'(delta_idx), 32'(held_i));
        end else begin
          exp = use_hand ? hand : model(e, w_mem[k]);
          check({name, "_data"}, 32'($signed(delta_data)), exp);
          check({name, "_idx"}, 32'(delta_idx), k);
          check({name, "_last"}, 32'(delta_last), 32'(k == N_IN - 1));
        end
        held_d = delta_data;
        held_i = delta_idx;
        if (k == abort_at) begin
          rst = 1'b1;
          delta_ready = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          check({name, "_rst_valid"}, 32'(delta_valid), 0);
          check({name, "_rst_start_ready"}, 32'(start_ready), 1);
          check({name, "_rst_busy"}, 32'(busy), 0);
          check({name, "_rst_rd_en"}, 32'(w_rd_en), 0);
          return;
        end
        if (inject && k == 20) begin
          start_valid = 1'b1;
          err_in = EW'($urandom);
          check({name, "_busy_start_ready"}, 32'(start_ready), 0);
        end
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      delta_ready = rdy;
      hs = delta_valid && rdy;
      prev_stall = delta_valid && !rdy;
      @(posedge clk); #1;
      if (hs) begin
        if (k == N_IN - 1) done = 1;
        k++;
      end
    end
    start_valid = 1'b0;
    delta_ready = 1'b0;
    check({name, "_done"}, 32'(done), 1);
    check({name, "_rd_cnt"}, rd_cnt, N_IN);
    check({name, "_end_start_ready"}, 32'(start_ready), 1);
    check({name, "_end_busy"}, 32'(busy), 0);
    if (!rnd) check({name, "_cycles"}, busy_cyc, 3 * N_IN);
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    delta_ready = 1'b0;
    err_in = '0;
    fill_const('0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_start_ready", 32'(start_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(w_rd_en), 0);
    check("rst_addr", 32'(w_addr), 0);
    check("rst_valid", 32'(delta_valid), 0);
    check("rst_data", 32'(delta_data), 0);
    check("rst_idx", 32'(delta_idx), 0);
    check("rst_last", 32'(delta_last), 0);

    for (int k = 0; k < N_IN; k++) w_mem[k] = {DATA_W'($urandom), DATA_W'($urandom), 9'd8};
    do_pass("scale", {9'd0, 9'd0, 9'd64}, 1'b0, 1'b1, 1, -1, 1'b0);

    fill_const({9'h0FF, 9'h0FF, 9'h0FF});
    do_pass("possat", {9'h0FF, 9'h0FF, 9'h0FF}, 1'b0, 1'b1, 255, -1, 1'b0);
    do_pass("negsat", {9'h100, 9'h100, 9'h100}, 1'b0, 1'b1, -256, -1, 1'b0);

    fill_const({9'd0, 9'd0, 9'd1});
    do_pass("floor", {9'd0, 9'd0, 9'h1FF}, 1'b0, 1'b1, -1, -1, 1'b0);

    fill_rand();
    do_pass("bp", EW'($urandom), 1'b1, 1'b0, 0, -1, 1'b0);
    do_pass("busy", EW'($urandom), 1'b0, 1'b0, 0, -1, 1'b1);
    do_pass("abort", EW'($urandom), 1'b0, 1'b0, 0, 40, 1'b0);
    do_pass("after", EW'($urandom), 1'b0, 1'b0, 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
